// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO push-port arbiter.
// Holds the flush-sequencer state encoding and the FIFO flag constants.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } arb_state_e;

  localparam logic [3:0] FLAG_FULL  = 4'h0;
  localparam int         DROP_CNT_W = 16;

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Combinational rotating-priority picker: one-hot winner is the first set
// request at or above p, wrapping to the lowest set request otherwise.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   p,
  output logic [NUM_REQ-1:0] winner
);

  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] upper;

  // Isolate the lowest set bit with x & -x, preferring requests at or above p.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      mask[i] = (i >= int'(p));
    end
    upper = req & mask;
    if (|upper) begin
      winner = upper & (~upper + NUM_REQ'(1));
    end else begin
      winner = req & (~req + NUM_REQ'(1));
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port between NUM_REQ byte producers,
// with full-flag back-pressure and a push-side flush sequencer. Option macro: PUSH_BURST_LOCK_EN.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int FLUSH_CYCLES = 4,
  parameter int MAX_BURST    = 4
) (
  input  logic                  Sys_Clk,
  input  logic                  Sys_Rst_N,
  input  logic [NUM_REQ-1:0]    Req,
  input  logic [8*NUM_REQ-1:0]  Req_Data,
  output logic [NUM_REQ-1:0]    Gnt,
  input  logic                  Flush_Req,
  output logic                  Flush_Busy,
  input  logic [3:0]            Fifo_Push_Flag,
  input  logic                  Fifo_Almost_Full,
  output logic [7:0]            Fifo_Din,
  output logic                  Fifo_Push,
  output logic                  Fifo_Push_Flush,
  output logic [DROP_CNT_W-1:0] Drop_Cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("fifo_push_arbiter: NUM_REQ must be 2..8");
  end
  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
    $error("fifo_push_arbiter: FLUSH_CYCLES must be 1..15");
  end
  if (MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_max_burst
    $error("fifo_push_arbiter: MAX_BURST must be 1..16");
  end

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

  arb_state_e         state;
  arb_state_e         state_nxt;
  logic [3:0]         flush_cnt;
  logic [3:0]         flush_cnt_nxt;
  logic [PTR_W-1:0]   ptr;
  logic               stall;
  logic               accept;
  logic [NUM_REQ-1:0] rr_gnt;
  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]   gnt_idx_p0;
  logic [7:0]         gnt_byte_p0;

  // Fifo_Push term: the byte already in flight when Almost_Full rises still lands.
  assign stall = !Sys_Rst_N || (state != RUN) || (Fifo_Push_Flag == FLAG_FULL) ||
                 (Fifo_Almost_Full && Fifo_Push);

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .PTR_W  (PTR_W)
  ) u_rr_pick (
    .req   (Req),
    .p     (ptr),
    .winner(rr_gnt)
  );

`ifdef PUSH_BURST_LOCK_EN
  localparam int BCNT_W = 5;

  logic               lock_vld;
  logic [NUM_REQ-1:0] lock_oh;
  logic               lock_hit;
  logic [BCNT_W-1:0]  burst_cnt;
  logic [BCNT_W-1:0]  burst_nxt;

  // The lock survives only while its owner keeps requesting; otherwise fall back to rr from ptr.
  assign lock_hit = lock_vld && |(lock_oh & Req);

  always_comb begin
    gnt       = '0;
    burst_nxt = BCNT_W'(1);
    if (!stall) begin
      gnt = lock_hit ? lock_oh : rr_gnt;
    end
    if (lock_hit) begin
      burst_nxt = burst_cnt + BCNT_W'(1);
    end
  end

  always_ff @(posedge Sys_Clk) begin
    if (!Sys_Rst_N) begin
      lock_vld  <= 1'b0;
      burst_cnt <= '0;
    end else if (accept) begin
      burst_cnt <= burst_nxt;
      lock_vld  <= (burst_nxt < BCNT_W'(MAX_BURST));
    end else begin
      lock_vld  <= 1'b0;
    end
  end

  always_ff @(posedge Sys_Clk) begin
    if (accept) begin
      lock_oh <= gnt;
    end
  end
`else
  always_comb begin
    gnt = '0;
    if (!stall) begin
      gnt = rr_gnt;
    end
  end
`endif

  assign Gnt    = gnt;
  assign accept = |gnt;

  always_comb begin
    gnt_idx_p0  = '0;
    gnt_byte_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx_p0  = PTR_W'(i);
        gnt_byte_p0 = Req_Data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    flush_cnt_nxt   = flush_cnt;
    Flush_Busy      = 1'b0;
    Fifo_Push_Flush = 1'b0;
    case (state)
      RUN: begin
        if (Flush_Req) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        Flush_Busy    = 1'b1;
        state_nxt     = FLUSH;
        flush_cnt_nxt = 4'(FLUSH_CYCLES - 1);
      end
      FLUSH: begin
        Flush_Busy      = 1'b1;
        Fifo_Push_Flush = 1'b1;
        if (flush_cnt == 4'd0) begin
          state_nxt = RUN;
        end else begin
          flush_cnt_nxt = flush_cnt - 4'd1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge Sys_Clk) begin
    if (!Sys_Rst_N) begin
      state     <= RUN;
      flush_cnt <= '0;
      ptr       <= '0;
      Drop_Cnt  <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      if (accept) begin
        ptr <= (gnt_idx_p0 == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx_p0 + PTR_W'(1);
      end
      if (Flush_Req && (state != RUN)) begin
        Drop_Cnt <= sat_inc(Drop_Cnt);
      end
    end
  end

  // p0 -> p1: accepted byte is presented to the FIFO one cycle after Gnt.
  always_ff @(posedge Sys_Clk) begin
    if (!Sys_Rst_N) begin
      Fifo_Push <= 1'b0;
      Fifo_Din  <= '0;
    end else begin
      Fifo_Push <= accept;
      if (accept) begin
        Fifo_Din <= gnt_byte_p0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Randomized scoreboard bench for fifo_push_arbiter against a queue/arithmetic reference model.
module tb_fifo_push_arbiter;

  localparam int N  = 4;
  localparam int FC = 4;
  localparam int MB = 4;
  localparam logic [31:0] FAIR_DATA = 32'hA3A2A1A0;

  logic            clk = 1'b0;
  logic            Sys_Rst_N;
  logic [N-1:0]    Req;
  logic [8*N-1:0]  Req_Data;
  logic [N-1:0]    Gnt;
  logic            Flush_Req;
  logic            Flush_Busy;
  logic [3:0]      Fifo_Push_Flag;
  logic            Fifo_Almost_Full;
  logic [7:0]      Fifo_Din;
  logic            Fifo_Push;
  logic            Fifo_Push_Flush;
  logic [15:0]     Drop_Cnt;

  always #5 clk = ~clk;

  fifo_push_arbiter #(
    .NUM_REQ     (N),
    .FLUSH_CYCLES(FC),
    .MAX_BURST   (MB)
  ) dut (
    .Sys_Clk         (clk),
    .Sys_Rst_N       (Sys_Rst_N),
    .Req             (Req),
    .Req_Data        (Req_Data),
    .Gnt             (Gnt),
    .Flush_Req       (Flush_Req),
    .Flush_Busy      (Flush_Busy),
    .Fifo_Push_Flag  (Fifo_Push_Flag),
    .Fifo_Almost_Full(Fifo_Almost_Full),
    .Fifo_Din        (Fifo_Din),
    .Fifo_Push       (Fifo_Push),
    .Fifo_Push_Flush (Fifo_Push_Flush),
    .Drop_Cnt        (Drop_Cnt)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  // Reference model: state 0=run 1=drain 2=flush
  int m_state, m_left, m_ptr, m_drop;
  bit m_push;
  bit m_lock;
  int m_lock_i, m_run;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_left = 0; m_ptr = 0; m_drop = 0;
    m_push = 1'b0; m_lock = 1'b0; m_lock_i = 0; m_run = 0;
    exp_q.delete();
  endtask

  task automatic step(input logic [N-1:0] req, input logic [3:0] flag, input logic af,
                      input logic fr, input logic [8*N-1:0] data);
    int win;
    bit stall;
    logic [N-1:0] eg;
    @(posedge clk); #1;
    Sys_Rst_N = 1'b1; Req = req; Fifo_Push_Flag = flag; Fifo_Almost_Full = af;
    Flush_Req = fr; Req_Data = data;
    @(negedge clk);
    stall = (m_state != 0) || (flag == 4'h0) || (af && m_push);
    win = -1;
    if (!stall) begin
`ifdef PUSH_BURST_LOCK_EN
      if (m_lock && req[m_lock_i]) win = m_lock_i;
`endif
      for (int d = 0; d < N; d++) begin
        if (win < 0 && req[(m_ptr + d) % N]) win = (m_ptr + d) % N;
      end
    end
    eg = '0;
    if (win >= 0) eg[win] = 1'b1;
    chk("gnt", 32'(Gnt), 32'(eg));
    chk("fifo_push", 32'(Fifo_Push), 32'(m_push));
    chk("flush_busy", 32'(Flush_Busy), 32'(m_state != 0));
    chk("push_flush", 32'(Fifo_Push_Flush), 32'(m_state == 2));
    chk("drop_cnt", 32'(Drop_Cnt), 32'(m_drop));
    chk("push_with_flush", 32'(Fifo_Push && Fifo_Push_Flush), 32'd0);
    // advance model to the state after the next clock edge
    if (win >= 0) begin
      exp_q.push_back(data[8*win +: 8]);
      m_ptr = (win + 1) % N;
      m_run = (m_lock && win == m_lock_i) ? m_run + 1 : 1;
      m_lock_i = win;
      m_lock = (m_run < MB);
    end else begin
      m_lock = 1'b0;
    end
    m_push = (win >= 0);
    if (fr && m_state != 0 && m_drop < 65535) m_drop++;
    case (m_state)
      0: if (fr) m_state = 1;
      1: begin m_state = 2; m_left = FC; end
      default: begin m_left--; if (m_left == 0) m_state = 0; end
    endcase
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    Sys_Rst_N = 1'b0; Req = '1; Flush_Req = 1'b0; Req_Data = 32'($urandom);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      chk("rst_gnt", 32'(Gnt), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("rst_push", 32'(Fifo_Push), 32'd0);
    chk("rst_din", 32'(Fifo_Din), 32'd0);
    chk("rst_push_flush", 32'(Fifo_Push_Flush), 32'd0);
    chk("rst_busy", 32'(Flush_Busy), 32'd0);
    chk("rst_drop", 32'(Drop_Cnt), 32'd0);
    model_reset();
  endtask

  // Monitor: every FIFO push must deliver the next expected byte.
  initial begin
    forever begin
      @(negedge clk);
      if (Fifo_Push === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL fifo_din: unexpected push of %0h at %0t", Fifo_Din, $time);
        end else begin
          chk("fifo_din", 32'(Fifo_Din), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    logic [3:0]   f;
    Sys_Rst_N = 1'b0; Req = '0; Req_Data = '0; Flush_Req = 1'b0;
    Fifo_Push_Flag = 4'hF; Fifo_Almost_Full = 1'b0;
    model_reset();

    do_reset(3);

    // fairness: all four requesting
    for (int i = 0; i < 8; i++) step(4'hF, 4'hF, 1'b0, 1'b0, FAIR_DATA);

    // full flag back-pressure, then Almost_Full with a push in flight
    for (int i = 0; i < 5; i++) step(4'h3, 4'h0, 1'b0, 1'b0, 32'($urandom));
    step(4'h3, 4'hF, 1'b0, 1'b0, 32'($urandom));
    step(4'h3, 4'hF, 1'b1, 1'b0, 32'($urandom));
    step(4'h3, 4'hF, 1'b1, 1'b0, 32'($urandom));
    step(4'h3, 4'hF, 1'b1, 1'b0, 32'($urandom));

    // flush, with a second request dropped during FLUSH
    step(4'hF, 4'hF, 1'b0, 1'b1, 32'($urandom));
    for (int i = 0; i < 7; i++) step(4'hF, 4'hF, 1'b0, (i == 2), 32'($urandom));

    // lone requester at the top, then wrap between 3 and 0
    for (int i = 0; i < 5; i++) step(4'h8, 4'hF, 1'b0, 1'b0, 32'($urandom));
    for (int i = 0; i < 10; i++) step(4'h9, 4'hF, 1'b0, 1'b0, 32'($urandom));

    // burst-style holding pattern with a mid-stream drop of Req[0]
    for (int i = 0; i < 10; i++) step(4'h3, 4'hF, 1'b0, 1'b0, 32'($urandom));
    step(4'h2, 4'hF, 1'b0, 1'b0, 32'($urandom));
    step(4'h3, 4'hF, 1'b0, 1'b0, 32'($urandom));

    // randomized traffic with a reset landing mid-flush
    for (int n = 0; n < 3000; n++) begin
      r = N'($urandom_range(0, 15));
      f = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if (n == 1500) begin
        step(r, f, 1'b0, 1'b1, 32'($urandom));
        step(r, f, 1'b0, 1'b0, 32'($urandom));
        step(r, f, 1'b0, 1'b0, 32'($urandom));
        do_reset(2);
      end else begin
        step(r, f, ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0), 32'($urandom));
      end
    end

    for (int i = 0; i < 3; i++) step('0, 4'hF, 1'b0, 1'b0, 32'($urandom));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
